// File: rtl/commit_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// commit_ctrl_pkg
// Shared constants for the in-order commit sequencer and its tag CAM.
//   DEPTH / PTR_W     : default number of in-flight entries and pointer width
//   DATA_W / PC_W     : register data width and PC/tag width
//   RD_W              : architectural register index width
//   NO_TAG            : reserved tag meaning "no producer"; never dispatched
//   TRUE / FALSE      : single-bit boolean constants
// ---------------------------------------------------------------------------
package commit_ctrl_pkg;

    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int RD_W   = 5;

    localparam logic [PC_W-1:0] NO_TAG = 32'h0000_0000;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage : commit_ctrl_pkg

// File: rtl/commit_tag_cam.sv
// ---------------------------------------------------------------------------
// commit_tag_cam
// DEPTH-wide tag comparator: reports whether any valid entry holds the key
// tag and, if so, the index of that entry.
//   valid : per-entry valid bits
//   tags  : per-entry PC tags
//   key   : tag being searched for (NO_TAG never hits)
//   hit   : some valid entry carries key
//   idx   : index of the matching entry (0 when no hit)
// ---------------------------------------------------------------------------
module commit_tag_cam #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int PC_W  = 32
) (
    input  logic [DEPTH-1:0]           valid,
    input  logic [DEPTH-1:0][PC_W-1:0] tags,
    input  logic [PC_W-1:0]            key,
    output logic                       hit,
    output logic [PTR_W-1:0]           idx
);
    import commit_ctrl_pkg::*;

    // Parallel compare; scanning downwards lets the lowest matching index win,
    // although valid tags are kept unique so at most one entry can match.
    always_comb begin
        hit = FALSE;
        idx = {PTR_W{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && (tags[i] == key) && (key != NO_TAG)) begin
                hit = TRUE;
                idx = PTR_W'(i);
            end else begin
                hit = hit;
                idx = idx;
            end
        end
    end

endmodule : commit_tag_cam

// File: rtl/commit_ctrl.sv
// ---------------------------------------------------------------------------
// commit_ctrl
// In-order commit sequencer between execution writeback and the register
// file. Entries are allocated in program order at dispatch, marked done on
// writeback, and retired from the head at most one per cycle. A faulting
// head flushes every in-flight entry and redirects fetch.
//   disp_valid/pc/rd, disp_ready : dispatch handshake (pc doubles as tag)
//   wb_valid/pc/data/exc/target  : execution writeback
//   is_finish_to_rf, rd/data/pc_to_rf : registered commit write port
//   is_exception_to_rf, flush_pc : registered one-cycle flush pulse
//   count                        : occupied entries
// ---------------------------------------------------------------------------
module commit_ctrl #(
    parameter int DEPTH  = commit_ctrl_pkg::DEPTH,
    parameter int PTR_W  = commit_ctrl_pkg::PTR_W,
    parameter int DATA_W = commit_ctrl_pkg::DATA_W,
    parameter int PC_W   = commit_ctrl_pkg::PC_W,
    parameter int RD_W   = commit_ctrl_pkg::RD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_valid,
    input  logic [PC_W-1:0]   disp_pc,
    input  logic [RD_W-1:0]   disp_rd,
    output logic              disp_ready,
    input  logic              wb_valid,
    input  logic [PC_W-1:0]   wb_pc,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_exc,
    input  logic [PC_W-1:0]   wb_target,
    output logic              is_finish_to_rf,
    output logic [RD_W-1:0]   rd_to_rf,
    output logic [DATA_W-1:0] data_to_rf,
    output logic [PC_W-1:0]   pc_to_rf,
    output logic              is_exception_to_rf,
    output logic [PC_W-1:0]   flush_pc,
    output logic [PTR_W:0]    count
);
    import commit_ctrl_pkg::*;

    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

    // Entry storage
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             done_q, done_d;
    logic [DEPTH-1:0]             exc_q, exc_d;
    logic [DEPTH-1:0][PC_W-1:0]   pc_q, pc_d;
    logic [DEPTH-1:0][PC_W-1:0]   target_q, target_d;
    logic [DEPTH-1:0][RD_W-1:0]   rd_q, rd_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

    // Queue bookkeeping
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Registered register-file interface
    logic              fin_q, fin_d;
    logic              flush_q, flush_d;
    logic [RD_W-1:0]   rd_out_q, rd_out_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [PC_W-1:0]   pc_out_q, pc_out_d;
    logic [PC_W-1:0]   flush_pc_q, flush_pc_d;

    // Lookup results and decode
    logic              wb_hit_s;
    logic [PTR_W-1:0]  wb_idx_s;
    logic              dup_hit_s;
    logic [PTR_W-1:0]  dup_idx_unused_s;
    logic              disp_ready_s;
    logic              disp_fire_s;
    logic              head_done_s;
    logic              head_retire_s;
    logic              head_flush_s;

    commit_tag_cam #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PC_W(PC_W)) u_wb_cam (
        .valid (valid_q),
        .tags  (pc_q),
        .key   (wb_pc),
        .hit   (wb_hit_s),
        .idx   (wb_idx_s)
    );

    commit_tag_cam #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PC_W(PC_W)) u_dup_cam (
        .valid (valid_q),
        .tags  (pc_q),
        .key   (disp_pc),
        .hit   (dup_hit_s),
        .idx   (dup_idx_unused_s)
    );

    // Dispatch acceptance and head-of-queue decode
    always_comb begin
        // A duplicate tag would make writeback ambiguous; the flush pulse
        // cycle refuses dispatch so the redirected stream starts clean.
        disp_ready_s  = (count_q != CNT_FULL) && !dup_hit_s && !flush_q;
        disp_fire_s   = disp_valid && disp_ready_s;
        head_done_s   = valid_q[head_q] && done_q[head_q];
        head_flush_s  = head_done_s && exc_q[head_q];
        head_retire_s = head_done_s && !exc_q[head_q];
    end

    // Next-state for entries, pointers and the register-file port
    always_comb begin
        valid_d    = valid_q;
        done_d     = done_q;
        exc_d      = exc_q;
        pc_d       = pc_q;
        target_d   = target_q;
        rd_d       = rd_q;
        data_d     = data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fin_d      = FALSE;
        flush_d    = FALSE;
        rd_out_d   = rd_out_q;
        data_out_d = data_out_q;
        pc_out_d   = pc_out_q;
        flush_pc_d = flush_pc_q;

        if (head_flush_s) begin
            // Faulting head: emit redirect with the link value and drop
            // everything, including any dispatch/writeback this cycle.
            flush_d    = TRUE;
            flush_pc_d = target_q[head_q];
            rd_out_d   = rd_q[head_q];
            data_out_d = data_q[head_q];
            valid_d    = {DEPTH{1'b0}};
            done_d     = {DEPTH{1'b0}};
            exc_d      = {DEPTH{1'b0}};
            head_d     = PTR_ZERO;
            tail_d     = PTR_ZERO;
            count_d    = CNT_ZERO;
        end else begin
            if (head_retire_s) begin
                valid_d[head_q] = FALSE;
                head_d          = head_q + PTR_ONE;
                // x0 writes are discarded but still retire the entry.
                if (rd_q[head_q] != {RD_W{1'b0}}) begin
                    fin_d      = TRUE;
                    rd_out_d   = rd_q[head_q];
                    data_out_d = data_q[head_q];
                    pc_out_d   = pc_q[head_q];
                end else begin
                    fin_d = FALSE;
                end
            end else begin
                head_d = head_q;
            end

            if (wb_valid && wb_hit_s) begin
                done_d[wb_idx_s]   = TRUE;
                exc_d[wb_idx_s]    = wb_exc;
                data_d[wb_idx_s]   = wb_data;
                target_d[wb_idx_s] = wb_target;
            end else begin
                done_d = done_d;
            end

            if (disp_fire_s) begin
                valid_d[tail_q] = TRUE;
                done_d[tail_q]  = FALSE;
                exc_d[tail_q]   = FALSE;
                pc_d[tail_q]    = disp_pc;
                rd_d[tail_q]    = disp_rd;
                tail_d          = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end

            count_d = count_q + CNT_W'(disp_fire_s) - CNT_W'(head_retire_s);
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= {DEPTH{1'b0}};
            done_q     <= {DEPTH{1'b0}};
            exc_q      <= {DEPTH{1'b0}};
            pc_q       <= {(DEPTH*PC_W){1'b0}};
            target_q   <= {(DEPTH*PC_W){1'b0}};
            rd_q       <= {(DEPTH*RD_W){1'b0}};
            data_q     <= {(DEPTH*DATA_W){1'b0}};
            head_q     <= PTR_ZERO;
            tail_q     <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            fin_q      <= FALSE;
            flush_q    <= FALSE;
            rd_out_q   <= {RD_W{1'b0}};
            data_out_q <= {DATA_W{1'b0}};
            pc_out_q   <= {PC_W{1'b0}};
            flush_pc_q <= {PC_W{1'b0}};
        end else begin
            valid_q    <= valid_d;
            done_q     <= done_d;
            exc_q      <= exc_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fin_q      <= fin_d;
            flush_q    <= flush_d;
            rd_out_q   <= rd_out_d;
            data_out_q <= data_out_d;
            pc_out_q   <= pc_out_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    assign disp_ready         = disp_ready_s;
    assign is_finish_to_rf    = fin_q;
    assign rd_to_rf           = rd_out_q;
    assign data_to_rf         = data_out_q;
    assign pc_to_rf           = pc_out_q;
    assign is_exception_to_rf = flush_q;
    assign flush_pc           = flush_pc_q;
    assign count              = count_q;

endmodule : commit_ctrl

// File: tb/tb_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_commit_ctrl
// Directed stimulus against commit_ctrl. A queue-based program-order model
// predicts every output; a negedge process compares DUT against the model
// each cycle, and directed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_valid;
    logic [31:0] disp_pc;
    logic [4:0]  disp_rd;
    logic        disp_ready;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_data;
    logic        wb_exc;
    logic [31:0] wb_target;
    logic        is_finish_to_rf;
    logic [4:0]  rd_to_rf;
    logic [31:0] data_to_rf;
    logic [31:0] pc_to_rf;
    logic        is_exception_to_rf;
    logic [31:0] flush_pc;
    logic [3:0]  count;

    always #5 clk = ~clk;

    commit_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .disp_valid         (disp_valid),
        .disp_pc            (disp_pc),
        .disp_rd            (disp_rd),
        .disp_ready         (disp_ready),
        .wb_valid           (wb_valid),
        .wb_pc              (wb_pc),
        .wb_data            (wb_data),
        .wb_exc             (wb_exc),
        .wb_target          (wb_target),
        .is_finish_to_rf    (is_finish_to_rf),
        .rd_to_rf           (rd_to_rf),
        .data_to_rf         (data_to_rf),
        .pc_to_rf           (pc_to_rf),
        .is_exception_to_rf (is_exception_to_rf),
        .flush_pc           (flush_pc),
        .count              (count)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        bit          done;
        bit          exc;
        logic [31:0] data;
        logic [31:0] target;
    } ent_t;

    ent_t        q[$];
    logic        m_fin = 1'b0;
    logic        m_exc = 1'b0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] m_data = 32'd0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_flush = 32'd0;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic bit model_ready();
        bit dup;
        dup = 1'b0;
        foreach (q[i]) if (q[i].pc == disp_pc) dup = 1'b1;
        return (q.size() != 8) && !dup && !m_exc;
    endfunction

    task automatic model_reset();
        q.delete();
        m_fin = 1'b0; m_exc = 1'b0; m_rd = 5'd0;
        m_data = 32'd0; m_pc = 32'd0; m_flush = 32'd0;
    endtask

    // One clock edge of program-order semantics, using inputs held at the edge.
    task automatic model_step();
        bit   acc;
        ent_t e;
        if (rst_n) begin
            acc   = disp_valid && model_ready();
            m_fin = 1'b0;
            m_exc = 1'b0;
            if (q.size() > 0 && q[0].done && q[0].exc) begin
                m_exc   = 1'b1;
                m_flush = q[0].target;
                m_rd    = q[0].rd;
                m_data  = q[0].data;
                q.delete();
            end else begin
                if (q.size() > 0 && q[0].done) begin
                    e = q.pop_front();
                    if (e.rd != 5'd0) begin
                        m_fin = 1'b1; m_rd = e.rd; m_data = e.data; m_pc = e.pc;
                    end
                end
                if (wb_valid) begin
                    foreach (q[i]) begin
                        if (q[i].pc == wb_pc) begin
                            q[i].done = 1'b1; q[i].exc = wb_exc;
                            q[i].data = wb_data; q[i].target = wb_target;
                        end
                    end
                end
                if (acc) begin
                    e.pc = disp_pc; e.rd = disp_rd; e.done = 1'b0; e.exc = 1'b0;
                    e.data = 32'd0; e.target = 32'd0;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_fin",   {31'd0, is_finish_to_rf},    {31'd0, m_fin});
        chk("cyc_exc",   {31'd0, is_exception_to_rf}, {31'd0, m_exc});
        chk("cyc_rd",    {27'd0, rd_to_rf},           {27'd0, m_rd});
        chk("cyc_data",  data_to_rf,                  m_data);
        chk("cyc_pc",    pc_to_rf,                    m_pc);
        chk("cyc_flush", flush_pc,                    m_flush);
        chk("cyc_count", {28'd0, count},              q.size());
        chk("cyc_ready", {31'd0, disp_ready},         {31'd0, model_ready()});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic disp(input logic [31:0] pc, input logic [4:0] rd);
        disp_valid = 1'b1; disp_pc = pc; disp_rd = rd;
    endtask

    task automatic disp_off();
        disp_valid = 1'b0; disp_pc = 32'd0; disp_rd = 5'd0;
    endtask

    task automatic wb(input logic [31:0] pc, input logic [31:0] data,
                      input logic exc, input logic [31:0] tgt);
        wb_valid = 1'b1; wb_pc = pc; wb_data = data; wb_exc = exc; wb_target = tgt;
    endtask

    task automatic wb_off();
        wb_valid = 1'b0; wb_pc = 32'd0; wb_data = 32'd0; wb_exc = 1'b0; wb_target = 32'd0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        disp_off();
        wb_off();

        // 1. asynchronous reset: outputs clear before any clock edge
        #1;
        chk("rst_fin",   {31'd0, is_finish_to_rf},    32'd0);
        chk("rst_exc",   {31'd0, is_exception_to_rf}, 32'd0);
        chk("rst_count", {28'd0, count},              32'd0);
        chk("rst_ready", {31'd0, disp_ready},         32'd1);
        chk("rst_data",  data_to_rf,                  32'd0);
        repeat (2) step();
        rst_n = 1'b1;

        // 2. single dispatch / writeback / commit
        disp(32'h100, 5'd5);
        step();
        chk("t2_count1", {28'd0, count}, 32'd1);
        disp_off();
        wb(32'h100, 32'hDEAD, 1'b0, 32'd0);
        step();
        chk("t2_nofin_yet", {31'd0, is_finish_to_rf}, 32'd0);
        wb_off();
        step();
        chk("t2_fin",   {31'd0, is_finish_to_rf}, 32'd1);
        chk("t2_rd",    {27'd0, rd_to_rf},        32'd5);
        chk("t2_data",  data_to_rf,               32'hDEAD);
        chk("t2_pc",    pc_to_rf,                 32'h100);
        chk("t2_count0",{28'd0, count},           32'd0);
        step();
        chk("t2_pulse1", {31'd0, is_finish_to_rf}, 32'd0);

        // 3. out-of-order writeback, in-order commit
        disp(32'h100, 5'd1); step();
        disp(32'h104, 5'd2); step();
        disp(32'h108, 5'd3); step();
        disp_off();
        wb(32'h108, 32'h3, 1'b0, 32'd0); step();
        wb(32'h104, 32'h2, 1'b0, 32'd0); step();
        chk("t3_wait", {31'd0, is_finish_to_rf}, 32'd0);
        wb(32'h100, 32'h1, 1'b0, 32'd0); step();
        wb_off();
        chk("t3_wait2", {31'd0, is_finish_to_rf}, 32'd0);
        step();
        chk("t3_c0", pc_to_rf, 32'h100);
        step();
        chk("t3_c1", pc_to_rf, 32'h104);
        chk("t3_f1", {31'd0, is_finish_to_rf}, 32'd1);
        step();
        chk("t3_c2", pc_to_rf, 32'h108);
        chk("t3_d2", data_to_rf, 32'h3);
        step();
        chk("t3_empty", {28'd0, count}, 32'd0);

        // 4. fill, full stall, wrap and simultaneous dispatch+commit
        for (int i = 0; i < 8; i++) begin
            disp(32'h400 + 32'(4 * i), 5'(i + 1));
            step();
        end
        disp(32'h420, 5'd9);
        #1;
        chk("t4_full_cnt",   {28'd0, count},      32'd8);
        chk("t4_full_ready", {31'd0, disp_ready}, 32'd0);
        wb(32'h400, 32'hA0, 1'b0, 32'd0); step();
        wb_off(); step();
        chk("t4_commit_pc", pc_to_rf,             32'h400);
        chk("t4_cnt7",      {28'd0, count},       32'd7);
        chk("t4_ready1",    {31'd0, disp_ready},  32'd1);
        step();
        chk("t4_cnt8", {28'd0, count}, 32'd8);
        disp(32'h424, 5'd10);
        wb(32'h404, 32'hA4, 1'b0, 32'd0); step();
        wb(32'h408, 32'hA8, 1'b0, 32'd0); step();
        wb_off();
        chk("t4_c404", pc_to_rf,       32'h404);
        chk("t4_c7b",  {28'd0, count}, 32'd7);
        step();
        chk("t4_c408",  pc_to_rf,       32'h408);
        chk("t4_same7", {28'd0, count}, 32'd7);
        disp(32'h428, 5'd11); step();
        chk("t4_c8b", {28'd0, count}, 32'd8);
        disp_off();
        for (int i = 0; i < 8; i++) begin
            wb(32'h40C + 32'(4 * i), 32'hB0 + 32'(i), 1'b0, 32'd0);
            step();
        end
        wb_off();
        repeat (3) step();
        chk("t4_last_pc", pc_to_rf,       32'h428);
        chk("t4_drained", {28'd0, count}, 32'd0);

        // 5. faulting head flushes everything
        disp(32'h200, 5'd1); step();
        disp(32'h204, 5'd2); step();
        disp_off();
        wb(32'h200, 32'h55, 1'b1, 32'h300); step();
        wb_off();
        disp(32'h208, 5'd3);
        step();
        chk("t5_exc",     {31'd0, is_exception_to_rf}, 32'd1);
        chk("t5_flushpc", flush_pc,                    32'h300);
        chk("t5_nofin",   {31'd0, is_finish_to_rf},    32'd0);
        chk("t5_link_rd", {27'd0, rd_to_rf},           32'd1);
        chk("t5_link_dt", data_to_rf,                  32'h55);
        chk("t5_cnt0",    {28'd0, count},              32'd0);
        chk("t5_ready0",  {31'd0, disp_ready},         32'd0);
        wb(32'h204, 32'h66, 1'b0, 32'd0);
        step();
        chk("t5_pulse1", {31'd0, is_exception_to_rf}, 32'd0);
        chk("t5_ready1", {31'd0, disp_ready},         32'd1);
        disp_off();
        wb(32'h204, 32'h66, 1'b0, 32'd0);
        step();
        wb_off();
        step();
        chk("t5_ignored_fin", {31'd0, is_finish_to_rf}, 32'd0);
        chk("t5_ignored_cnt", {28'd0, count},           32'd0);

        // 6. duplicate-tag stall and rd=0 retire
        disp(32'h100, 5'd0); step();
        #1;
        chk("t6_dup", {31'd0, disp_ready}, 32'd0);
        disp_off();
        wb(32'h100, 32'h99, 1'b0, 32'd0); step();
        wb_off(); step();
        chk("t6_x0_nofin", {31'd0, is_finish_to_rf}, 32'd0);
        chk("t6_x0_cnt",   {28'd0, count},           32'd0);
        chk("t6_x0_hold",  pc_to_rf,                 32'h428);
        disp(32'h104, 5'd7); step();
        disp_off();
        wb(32'h104, 32'h1234, 1'b0, 32'd0); step();
        wb_off(); step();
        chk("t6_next_fin", {31'd0, is_finish_to_rf}, 32'd1);
        chk("t6_next_pc",  pc_to_rf,                 32'h104);
        chk("t6_next_rd",  {27'd0, rd_to_rf},        32'd7);

        // Mid-operation asynchronous reset drops a committable entry
        disp(32'h600, 5'd9); step();
        disp_off();
        wb(32'h600, 32'h77, 1'b0, 32'd0); step();
        wb_off();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mr_cnt",   {28'd0, count},      32'd0);
        chk("mr_ready", {31'd0, disp_ready}, 32'd1);
        chk("mr_pc",    pc_to_rf,            32'd0);
        chk("mr_rd",    {27'd0, rd_to_rf},   32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("mr_nofin", {31'd0, is_finish_to_rf},    32'd0);
        chk("mr_noexc", {31'd0, is_exception_to_rf}, 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_commit_ctrl
